// File: rtl/mips_defs.sv
// Shared encodings for the MIPS ID stage: opcodes, funct codes, ALU control,
// PC source selection and the decoded-control bundle.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_e;

  // Control bits that travel down the pipeline in ID/EX.
  typedef struct packed {
    logic      reg_write;
    logic      mem_to_reg;
    logic      mem_read;
    logic      mem_write;
    logic      alu_src;
    logic      reg_dst;
    alu_ctrl_e alu_ctrl;
  } ex_ctrl_t;

  // Full decode result; branch/jump/rt_src are consumed inside ID only.
  typedef struct packed {
    ex_ctrl_t ex;
    logic     branch;
    logic     bne;
    logic     jump;
    logic     rt_src;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct);
    dec_t d;
    d = '0;
    case (op)
      OP_RTYPE: begin
        d.ex.reg_write = 1'b1;
        d.ex.reg_dst   = 1'b1;
        d.rt_src       = 1'b1;
        case (funct)
          FN_ADD:  d.ex.alu_ctrl = ALU_ADD;
          FN_SUB:  d.ex.alu_ctrl = ALU_SUB;
          FN_AND:  d.ex.alu_ctrl = ALU_AND;
          FN_OR:   d.ex.alu_ctrl = ALU_OR;
          FN_SLT:  d.ex.alu_ctrl = ALU_SLT;
          default: d = '0;
        endcase
      end
      OP_LW: begin
        d.ex.reg_write  = 1'b1;
        d.ex.mem_to_reg = 1'b1;
        d.ex.mem_read   = 1'b1;
        d.ex.alu_src    = 1'b1;
        d.ex.alu_ctrl   = ALU_ADD;
      end
      OP_SW: begin
        d.ex.mem_write = 1'b1;
        d.ex.alu_src   = 1'b1;
        d.ex.alu_ctrl  = ALU_ADD;
        d.rt_src       = 1'b1;
      end
      OP_ADDI: begin
        d.ex.reg_write = 1'b1;
        d.ex.alu_src   = 1'b1;
        d.ex.alu_ctrl  = ALU_ADD;
      end
      OP_BEQ: begin
        d.ex.alu_ctrl = ALU_SUB;
        d.branch      = 1'b1;
        d.rt_src      = 1'b1;
      end
      OP_BNE: begin
        d.ex.alu_ctrl = ALU_SUB;
        d.branch      = 1'b1;
        d.bne         = 1'b1;
        d.rt_src      = 1'b1;
      end
      OP_J:    d.jump = 1'b1;
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32-entry register file: two combinational read ports with write-through
// bypass from the single write port; register 0 is hardwired to zero.
module reg_file #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0]     rdata1,
  output logic [DATA_W-1:0]     rdata2
);

  localparam int DEPTH = 1 << REG_ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: this array is reset so the architectural state starts at zero; that
  // forces flops rather than a RAM macro, which is acceptable at 32 entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      // NOTE: non-blocking so every reader in this edge sees the old value.
      mem[waddr] <= wdata;
    end
  end

  // A nonzero read index implies a nonzero write index on a bypass hit.
  assign rdata1 = (raddr1 == '0)            ? '0    :
                  (we && raddr1 == waddr)   ? wdata : mem[raddr1];
  assign rdata2 = (raddr2 == '0)            ? '0    :
                  (we && raddr2 == waddr)   ? wdata : mem[raddr2];

endmodule

// File: rtl/id_stage.sv
// MIPS Instruction Decode stage: decode, register read, hazard detection,
// branch/jump resolution in ID and the ID/EX pipeline register.
module id_stage
  import mips_defs::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     IF_ID_next_i_addr,
  input  logic [DATA_W-1:0]     IF_ID_instruction,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_write_reg,
  input  logic [DATA_W-1:0]     wb_write_data,
  input  logic                  ex_mem_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_mem_write_reg,
  output logic                  pc_write,
  output logic                  if_id_write_en,
  output logic [1:0]            pc_source,
  output logic [DATA_W-1:0]     branch_addr,
  output logic [DATA_W-1:0]     jump_addr,
  output logic [DATA_W-1:0]     ID_EX_next_i_addr,
  output logic [DATA_W-1:0]     ID_EX_reg_data1,
  output logic [DATA_W-1:0]     ID_EX_reg_data2,
  output logic [DATA_W-1:0]     ID_EX_sign_ext_imm,
  output logic [REG_ADDR_W-1:0] ID_EX_rs,
  output logic [REG_ADDR_W-1:0] ID_EX_rt,
  output logic [REG_ADDR_W-1:0] ID_EX_rd,
  output logic                  ID_EX_reg_write,
  output logic                  ID_EX_mem_to_reg,
  output logic                  ID_EX_mem_read,
  output logic                  ID_EX_mem_write,
  output logic                  ID_EX_alu_src,
  output logic                  ID_EX_reg_dst,
  output logic [3:0]            ID_EX_alu_ctrl
);

  logic [5:0]            op;
  logic [5:0]            funct;
  logic [REG_ADDR_W-1:0] rs, rt, rd;
  logic [15:0]           imm16;
  logic [DATA_W-1:0]     sign_ext;
  logic [DATA_W-1:0]     rd1, rd2;
  logic [REG_ADDR_W-1:0] ex_dest;
  dec_t                  dec;
  ex_ctrl_t              id_ex_ctrl_q;
  logic                  squash_q;
  logic                  load_use, branch_hazard, stall, bubble;
  pc_src_e               pc_src;

  assign op       = IF_ID_instruction[31:26];
  assign rs       = IF_ID_instruction[25:21];
  assign rt       = IF_ID_instruction[20:16];
  assign rd       = IF_ID_instruction[15:11];
  assign funct    = IF_ID_instruction[5:0];
  assign imm16    = IF_ID_instruction[15:0];
  assign sign_ext = {{(DATA_W-16){imm16[15]}}, imm16};
  assign dec      = decode(op, funct);

  reg_file #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_reg_write),
    .waddr  (wb_write_reg),
    .wdata  (wb_write_data),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  assign branch_addr = IF_ID_next_i_addr + {sign_ext[DATA_W-3:0], 2'b00};
  assign jump_addr   = {IF_ID_next_i_addr[DATA_W-1:DATA_W-4], IF_ID_instruction[25:0], 2'b00};

  // A load in EX cannot forward to the next instruction, so it must wait.
  assign load_use = id_ex_ctrl_q.mem_read && ID_EX_rt != '0 &&
                    (ID_EX_rt == rs || (dec.rt_src && ID_EX_rt == rt));

  // Branches compare in ID, so their operands must already be in the file.
  assign ex_dest = id_ex_ctrl_q.reg_dst ? ID_EX_rd : ID_EX_rt;
  assign branch_hazard = dec.branch && (
      (id_ex_ctrl_q.reg_write && ex_dest != '0 && (ex_dest == rs || ex_dest == rt)) ||
      (ex_mem_mem_read && ex_mem_write_reg != '0 &&
       (ex_mem_write_reg == rs || ex_mem_write_reg == rt)));

  // NOTE: every output of this block gets a default first so no latch forms.
  always_comb begin
    stall  = 1'b0;
    pc_src = PC_SEQ;
    if (!squash_q) begin
      stall = load_use || branch_hazard;
      if (!stall) begin
        if (dec.jump)
          pc_src = PC_JUMP;
        else if (dec.branch && (dec.bne ^ (rd1 == rd2)))
          pc_src = PC_BRANCH;
      end
    end
  end

  assign bubble         = squash_q || stall;
  assign pc_write       = !stall;
  assign if_id_write_en = !stall;
  assign pc_source      = pc_src;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      squash_q           <= 1'b0;
      id_ex_ctrl_q       <= '0;
      ID_EX_next_i_addr  <= '0;
      ID_EX_reg_data1    <= '0;
      ID_EX_reg_data2    <= '0;
      ID_EX_sign_ext_imm <= '0;
      ID_EX_rs           <= '0;
      ID_EX_rt           <= '0;
      ID_EX_rd           <= '0;
    end else begin
      squash_q           <= (pc_src != PC_SEQ);
      id_ex_ctrl_q       <= bubble ? '0 : dec.ex;
      ID_EX_next_i_addr  <= IF_ID_next_i_addr;
      ID_EX_reg_data1    <= rd1;
      ID_EX_reg_data2    <= rd2;
      ID_EX_sign_ext_imm <= sign_ext;
      ID_EX_rs           <= rs;
      ID_EX_rt           <= rt;
      ID_EX_rd           <= rd;
    end
  end

  assign ID_EX_reg_write  = id_ex_ctrl_q.reg_write;
  assign ID_EX_mem_to_reg = id_ex_ctrl_q.mem_to_reg;
  assign ID_EX_mem_read   = id_ex_ctrl_q.mem_read;
  assign ID_EX_mem_write  = id_ex_ctrl_q.mem_write;
  assign ID_EX_alu_src    = id_ex_ctrl_q.alu_src;
  assign ID_EX_reg_dst    = id_ex_ctrl_q.reg_dst;
  assign ID_EX_alu_ctrl   = id_ex_ctrl_q.alu_ctrl;

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage: inputs change on the falling edge,
// combinational outputs are sampled 1 ns later, ID/EX 1 ns after the rising edge.
module tb_id_stage;
  import mips_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_i_addr, instr, wb_data;
  logic        wb_we, exm_rd;
  logic [4:0]  wb_reg, exm_reg;

  logic        pc_write, if_id_write_en;
  logic [1:0]  pc_source;
  logic [31:0] branch_addr, jump_addr;
  logic [31:0] ex_pc, ex_d1, ex_d2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst;
  logic [3:0]  ex_alu;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk                (clk),
    .rst                (rst),
    .IF_ID_next_i_addr  (next_i_addr),
    .IF_ID_instruction  (instr),
    .wb_reg_write       (wb_we),
    .wb_write_reg       (wb_reg),
    .wb_write_data      (wb_data),
    .ex_mem_mem_read    (exm_rd),
    .ex_mem_write_reg   (exm_reg),
    .pc_write           (pc_write),
    .if_id_write_en     (if_id_write_en),
    .pc_source          (pc_source),
    .branch_addr        (branch_addr),
    .jump_addr          (jump_addr),
    .ID_EX_next_i_addr  (ex_pc),
    .ID_EX_reg_data1    (ex_d1),
    .ID_EX_reg_data2    (ex_d2),
    .ID_EX_sign_ext_imm (ex_imm),
    .ID_EX_rs           (ex_rs),
    .ID_EX_rt           (ex_rt),
    .ID_EX_rd           (ex_rd),
    .ID_EX_reg_write    (ex_reg_write),
    .ID_EX_mem_to_reg   (ex_mem_to_reg),
    .ID_EX_mem_read     (ex_mem_read),
    .ID_EX_mem_write    (ex_mem_write),
    .ID_EX_alu_src      (ex_alu_src),
    .ID_EX_reg_dst      (ex_reg_dst),
    .ID_EX_alu_ctrl     (ex_alu)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] s, t, d);
    return {OP_RTYPE, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] s, t,
                                        input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  function automatic logic [31:0] j_ins(input logic [25:0] target);
    return {OP_J, target};
  endfunction

  // Apply one ID-stage input vector on the falling edge, then let it settle.
  task automatic drive(input logic [31:0] pc, input logic [31:0] ins,
                       input logic we = 1'b0, input logic [4:0] wr = 5'd0,
                       input logic [31:0] wd = 32'd0,
                       input logic mr = 1'b0, input logic [4:0] mreg = 5'd0);
    @(negedge clk);
    next_i_addr = pc; instr = ins;
    wb_we = we; wb_reg = wr; wb_data = wd;
    exm_rd = mr; exm_reg = mreg;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    next_i_addr = 32'h44; instr = r_ins(FN_ADD, 5'd0, 5'd0, 5'd10);
    wb_we = 1'b0; wb_reg = '0; wb_data = '0; exm_rd = 1'b0; exm_reg = '0;
    #1 rst = 1'b0;

    // Reset holds ID/EX at zero across a clock edge.
    tick();
    check("rst_pc", ex_pc, 32'h0);
    check("rst_reg_write", ex_reg_write, 1'b0);
    check("rst_squash", dut.squash_q, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // add r3,r5,r0 with WB writing r5 in the same cycle: bypass.
    drive(32'h004, r_ins(FN_ADD, 5'd5, 5'd0, 5'd3), 1'b1, 5'd5, 32'h1234);
    check("add_pc_write", pc_write, 1'b1);
    tick();
    check("bypass_d1", ex_d1, 32'h1234);
    check("bypass_d2", ex_d2, 32'h0);
    check("add_rd", ex_rd, 5'd3);
    check("add_reg_write", ex_reg_write, 1'b1);
    check("add_reg_dst", ex_reg_dst, 1'b1);
    check("add_alu", ex_alu, 4'b0010);

    // WB write to r0 is ignored; r5 now comes from storage.
    drive(32'h008, r_ins(FN_ADD, 5'd0, 5'd5, 5'd6), 1'b1, 5'd0, 32'hDEAD);
    tick();
    check("r0_read", ex_d1, 32'h0);
    check("r5_stored", ex_d2, 32'h1234);

    drive(32'h00C, r_ins(FN_SLT, 5'd5, 5'd5, 5'd9));
    tick();
    check("slt_alu", ex_alu, 4'b0111);
    drive(32'h010, r_ins(FN_SUB, 5'd5, 5'd5, 5'd9));
    tick();
    check("sub_alu", ex_alu, 4'b0110);

    // lw r2,0(r1) then add r4,r2,r2: one load-use stall.
    drive(32'h014, i_ins(OP_LW, 5'd1, 5'd2, 16'h0));
    tick();
    check("lw_mem_read", ex_mem_read, 1'b1);
    check("lw_mem_to_reg", ex_mem_to_reg, 1'b1);
    check("lw_alu_src", ex_alu_src, 1'b1);
    check("lw_rt", ex_rt, 5'd2);
    drive(32'h018, r_ins(FN_ADD, 5'd2, 5'd2, 5'd4));
    check("lu_pc_write", pc_write, 1'b0);
    check("lu_if_id_en", if_id_write_en, 1'b0);
    check("lu_pc_source", pc_source, 2'b00);
    tick();
    check("lu_bubble", ex_reg_write, 1'b0);
    check("lu_bubble_alu", ex_alu, 4'b0000);
    check("lu_rs_loads", ex_rs, 5'd2);
    drive(32'h018, r_ins(FN_ADD, 5'd2, 5'd2, 5'd4));
    check("lu_release", pc_write, 1'b1);
    tick();
    check("lu_add_issue", ex_reg_write, 1'b1);
    check("lu_add_rd", ex_rd, 5'd4);

    // beq r1,r1,+3 at 0x100: taken, then one squashed slot (a j here).
    drive(32'h100, i_ins(OP_BEQ, 5'd1, 5'd1, 16'd3));
    check("beq_pc_source", pc_source, 2'b01);
    check("beq_addr", branch_addr, 32'h10C);
    check("beq_pc_write", pc_write, 1'b1);
    tick();
    check("beq_squash_set", dut.squash_q, 1'b1);
    drive(32'h104, j_ins(26'h40));
    check("sq_no_jump", pc_source, 2'b00);
    check("sq_pc_write", pc_write, 1'b1);
    tick();
    check("sq_cleared", dut.squash_q, 1'b0);

    // j 0x40 with PC+4 = 0x2000_0004, then a squashed add.
    drive(32'h2000_0004, j_ins(26'h40));
    check("j_pc_source", pc_source, 2'b10);
    check("j_addr", jump_addr, 32'h2000_0100);
    tick();
    drive(32'h2000_0008, r_ins(FN_ADD, 5'd1, 5'd1, 5'd8));
    check("j_sq_pc_source", pc_source, 2'b00);
    tick();
    check("j_sq_bubble", ex_reg_write, 1'b0);
    check("j_sq_alu", ex_alu, 4'b0000);
    check("j_sq_pc_loads", ex_pc, 32'h2000_0008);

    drive(32'h2000_000C, i_ins(OP_SW, 5'd1, 5'd8, 16'd4));
    tick();
    check("sw_mem_write", ex_mem_write, 1'b1);
    check("sw_reg_write", ex_reg_write, 1'b0);
    check("sw_imm", ex_imm, 32'h4);

    // addi r7,r0,-1 then bne r7,r0,-2: one branch-operand stall, then taken.
    drive(32'h1FC, i_ins(OP_ADDI, 5'd0, 5'd7, 16'hFFFF));
    tick();
    check("addi_imm", ex_imm, 32'hFFFF_FFFF);
    check("addi_reg_dst", ex_reg_dst, 1'b0);
    check("addi_reg_write", ex_reg_write, 1'b1);
    drive(32'h200, i_ins(OP_BNE, 5'd7, 5'd0, 16'hFFFE));
    check("bne_stall", pc_write, 1'b0);
    check("bne_stall_src", pc_source, 2'b00);
    tick();
    check("bne_bubble", ex_reg_write, 1'b0);
    drive(32'h200, i_ins(OP_BNE, 5'd7, 5'd0, 16'hFFFE), 1'b1, 5'd7, 32'hFFFF_FFFF);
    check("bne_taken", pc_source, 2'b01);
    check("bne_addr", branch_addr, 32'h1F8);
    check("bne_pc_write", pc_write, 1'b1);
    tick();
    drive(32'h204, r_ins(FN_ADD, 5'd7, 5'd0, 5'd9));
    tick();
    check("bne_sq_bubble", ex_reg_write, 1'b0);
    check("r7_stored", ex_d1, 32'hFFFF_FFFF);

    // Load in MEM writing a branch operand stalls; dest r0 does not.
    drive(32'h300, i_ins(OP_BEQ, 5'd7, 5'd7, 16'd1), 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    check("exm_stall", pc_write, 1'b0);
    tick();
    drive(32'h300, i_ins(OP_BEQ, 5'd7, 5'd7, 16'd1), 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    check("exm_r0_no_stall", pc_write, 1'b1);
    check("exm_beq_taken", pc_source, 2'b01);
    check("exm_beq_addr", branch_addr, 32'h304);
    tick();

    // Mid-run reset with a squash pending.
    #2 rst = 1'b0;
    #1;
    check("mid_rst_pc", ex_pc, 32'h0);
    check("mid_rst_squash", dut.squash_q, 1'b0);
    check("mid_rst_rs", ex_rs, 5'd0);
    rst = 1'b1;
    drive(32'h400, r_ins(FN_ADD, 5'd7, 5'd0, 5'd9));
    check("post_rst_src", pc_source, 2'b00);
    tick();
    check("post_rst_issue", ex_reg_write, 1'b1);
    check("post_rst_rf_clear", ex_d1, 32'h0);
    check("post_rst_rd", ex_rd, 5'd9);

    // Unknown opcode and unknown funct decode to bubbles.
    drive(32'h404, {6'h3F, 26'h3FF_FFFF});
    tick();
    check("bad_op_reg_write", ex_reg_write, 1'b0);
    check("bad_op_alu_src", ex_alu_src, 1'b0);
    drive(32'h408, r_ins(6'h21, 5'd1, 5'd2, 5'd3));
    tick();
    check("bad_fn_reg_write", ex_reg_write, 1'b0);
    check("bad_fn_reg_dst", ex_reg_dst, 1'b0);

    // Not-taken cases: bne on equal, beq on unequal (bypassed r9 = 5).
    drive(32'h40C, i_ins(OP_BNE, 5'd0, 5'd0, 16'd5));
    check("bne_not_taken", pc_source, 2'b00);
    tick();
    drive(32'h410, i_ins(OP_BEQ, 5'd0, 5'd9, 16'd5), 1'b1, 5'd9, 32'd5);
    check("beq_not_taken", pc_source, 2'b00);
    check("beq_nt_pc_write", pc_write, 1'b1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
